// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the fifo burst reader: word geometry, burst
// length width default and the controller state encoding.
package fifo_rd_pkg;

    localparam int IL_DEF    = 4;
    localparam int FL_DEF    = 16;
    localparam int LEN_W_DEF = 6;

    // Fixed-point word width is integer plus fraction bits.
    function automatic int data_w(input int il, input int fl);
        return il + fl;
    endfunction

    localparam int DATA_W_DEF = data_w(IL_DEF, FL_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order skid buffer. Entry 0 is always the head. Push while
// full without a pop is dropped; the reader never issues one.
module fifo_rd_skid #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o,
    output logic         valid_o
);

    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;

    // Next entry contents and occupancy for every push/pop combination.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push_i) begin
                    e0_d  = data_i;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                case ({push_i, pop_i})
                    2'b11: e0_d = data_i;
                    2'b10: begin
                        e1_d  = data_i;
                        cnt_d = 2'd2;
                    end
                    2'b01: cnt_d = 2'd0;
                    default: ;
                endcase
            end
            2'd2: begin
                if (pop_i) begin
                    e0_d = e1_q;
                    if (push_i) e1_d = data_i;
                    else        cnt_d = 2'd1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = valid_o ? e0_q : '0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pulls burst_len words from an upstream registered-empty
// fifo and hands them downstream over valid/ready, never holding more than
// two words (buffered plus in flight).
// Optional macro FIFO_BURST_READER_WCNT_EN adds words_out, the count of
// words transferred in the current burst.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter  int IL     = IL_DEF,
    parameter  int FL     = FL_DEF,
    parameter  int LEN_W  = LEN_W_DEF,
    localparam int DATA_W = data_w(IL, FL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef FIFO_BURST_READER_WCNT_EN
    ,
    output logic [LEN_W-1:0]  words_out
`endif
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              infl_q;
    logic [1:0]        cnt;
    logic              xfer, grant;
    logic [2:0]        occ;

    // Occupancy after this edge's pop; a new read only fits below two.
    assign xfer  = out_valid && out_ready;
    assign occ   = {1'b0, cnt} + {2'b00, infl_q} - {2'b00, xfer};
    assign grant = fifo_rd_en && !fifo_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: zero-length bursts go straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (burst_len != '0) ? ST_RUN : ST_DONE;
            ST_RUN:   if (grant && rem_q == LEN_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (!infl_q && cnt == 2'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state plus the read-permission check.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        fifo_rd_en = (state_q == ST_RUN) && !fifo_empty &&
                     (rem_q != '0) && (occ < 3'd2);
    end

    // Remaining count: loaded on start accept, decremented per grant.
    always_comb begin
        rem_d = rem_q;
        if (state_q == ST_IDLE && start) rem_d = burst_len;
        else if (grant)                  rem_d = rem_q - LEN_W'(1);
    end

    // Remaining counter and in-flight flag (data arrives one cycle late).
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            infl_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            infl_q <= grant;
        end
    end

    fifo_rd_skid #(.W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .push_i  (infl_q),
        .data_i  (fifo_data),
        .pop_i   (xfer),
        .count_o (cnt),
        .head_o  (out_data),
        .valid_o (out_valid)
    );

`ifdef FIFO_BURST_READER_WCNT_EN
    logic [LEN_W-1:0] wcnt_q;

    // Transfer counter, cleared when a burst is accepted, held afterwards.
    always_ff @(posedge clk) begin
        if (reset)                            wcnt_q <= '0;
        else if (state_q == ST_IDLE && start) wcnt_q <= '0;
        else if (xfer)                        wcnt_q <= wcnt_q + LEN_W'(1);
    end

    assign words_out = wcnt_q;
`endif

endmodule
